crypt_stream_engine: RTL

CRYPT_STREAM_ENGINE -- requirements
Module: crypt_stream_engine

---
 rtl/crypt_stream_engine.sv | 106 ++++++++++
 1 files changed

// File: rtl/crypt_stream_engine.sv
// Iterative rotate/XOR block cipher with valid/ready handshakes.
// Each accepted block runs one round per clock and is then held until the consumer takes it.
module crypt_stream_engine #(
    parameter int DATA_W = 8,
    parameter int ROUNDS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DATA_W-1:0] key,
    input  logic              mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic [15:0]       blk_cnt
);
    localparam int CW = $clog2(ROUNDS + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        r_state;
    logic [CW-1:0]     r_cnt;
    logic [DATA_W-1:0] r_x;
    logic [DATA_W-1:0] r_key;
    logic              r_mode;
    logic [15:0]       r_blk;

    logic [CW-1:0]     w_ridx;
    logic [63:0]       w_ridx_ext;
    logic [31:0]       w_sh;
    logic [DATA_W-1:0] w_kr;
    logic [DATA_W-1:0] w_x_next;
    logic              w_last;

    // Upper half of the doubled word shifted left is the left rotation for s < DATA_W.
    function automatic logic [DATA_W-1:0] f_rotl(input logic [DATA_W-1:0] v, input logic [31:0] s);
        logic [2*DATA_W-1:0] t;
        t = {v, v} << s;
        return t[2*DATA_W-1 -: DATA_W];
    endfunction

    // Decrypt walks the round keys in reverse, so the index counts down from ROUNDS-1.
    always_comb begin
        w_ridx     = r_mode ? (CW'(ROUNDS - 1) - r_cnt) : r_cnt;
        w_ridx_ext = 64'(w_ridx);
        w_sh       = 32'(w_ridx) % 32'(DATA_W);
        w_kr       = f_rotl(r_key, w_sh) ^ w_ridx_ext[DATA_W-1:0];
        if (r_mode) begin
            w_x_next = {r_x[0], r_x[DATA_W-1:1]} ^ w_kr;
        end else begin
            w_x_next = (r_x ^ w_kr) << 1 | (r_x ^ w_kr) >> (DATA_W - 1);
        end
        w_last = (r_cnt == CW'(ROUNDS - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_x     <= '0;
            r_key   <= '0;
            r_mode  <= 1'b0;
            r_blk   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_x     <= in_data;
                        r_key   <= key;
                        r_mode  <= mode;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_x <= w_x_next;
                    if (w_last) begin
                        r_cnt   <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_blk   <= r_blk + 16'd1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign out_data  = r_x;
    assign blk_cnt   = r_blk;

endmodule
